// File: rtl/imm_gen_pipe_if.sv
// Handshake bundle for imm_gen_pipe.
// slave is the decoder's view, master the producer/consumer side.
interface imm_gen_pipe_if #(
    parameter int XLEN = 32
);
    logic            i_flush;
    logic            i_valid;
    logic            o_ready;
    logic [31:0]     i_instr;
    logic            o_valid;
    logic            i_ready;
    logic [XLEN-1:0] o_imm;
    logic [2:0]      o_fmt;
    logic            o_known;

    modport slave (
        input  i_flush, i_valid, i_instr, i_ready,
        output o_ready, o_valid, o_imm, o_fmt, o_known
    );

    modport master (
        output i_flush, i_valid, i_instr, i_ready,
        input  o_ready, o_valid, o_imm, o_fmt, o_known
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// RISC-V immediate decoder feeding a 2-entry elastic buffer.
// Decode is combinational; main drives outputs, skid absorbs one overflow.
module imm_gen_pipe #(
    parameter int XLEN     = 32,
    parameter int EN_CSR   = 1,
    parameter int EN_SHAMT = 1
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    imm_gen_pipe_if.slave bus
);
    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_CSR  = 3'd6
    } fmt_e;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic            known;
    } entry_t;

    logic [31:0] ins;
    logic [6:0]  op;
    logic [2:0]  f3;

    assign ins = bus.i_instr;
    assign op  = ins[6:0];
    assign f3  = ins[14:12];

    logic is_i, is_sh, is_s, is_b, is_u, is_j, is_csr;

    assign is_sh  = (EN_SHAMT != 0) && (op == 7'b0010011)
                 && ((f3 == 3'b001) || (f3 == 3'b101));
    assign is_i   = !is_sh && ((op == 7'b0010011)
                 || (op == 7'b0000011) || (op == 7'b1100111));
    assign is_s   = (op == 7'b0100011);
    assign is_b   = (op == 7'b1100011);
    assign is_u   = (op == 7'b0110111) || (op == 7'b0010111);
    assign is_j   = (op == 7'b1101111);
    assign is_csr = (EN_CSR != 0) && (op == 7'b1110011) && ins[14];

    // RV64 shifts use a 6-bit shamt, RV32 only 5 bits
    logic [XLEN-1:0] shamt;
    assign shamt = (XLEN == 64) ? XLEN'(ins[25:20])
                                : XLEN'(ins[24:20]);

    entry_t dec;

    always_comb begin
        dec = '0;
        unique case (1'b1)
            is_sh: begin
                dec.imm = shamt;
                dec.fmt = FMT_I;
            end
            is_i: begin
                dec.imm = XLEN'($signed(ins[31:20]));
                dec.fmt = FMT_I;
            end
            is_s: begin
                dec.imm = XLEN'($signed({ins[31:25], ins[11:7]}));
                dec.fmt = FMT_S;
            end
            is_b: begin
                dec.imm = XLEN'($signed({ins[31], ins[7],
                          ins[30:25], ins[11:8], 1'b0}));
                dec.fmt = FMT_B;
            end
            is_u: begin
                dec.imm = XLEN'($signed({ins[31:12], 12'b0}));
                dec.fmt = FMT_U;
            end
            is_j: begin
                dec.imm = XLEN'($signed({ins[31], ins[19:12],
                          ins[20], ins[30:21], 1'b0}));
                dec.fmt = FMT_J;
            end
            is_csr: begin
                dec.imm = XLEN'(ins[19:15]);
                dec.fmt = FMT_CSR;
            end
            default: ;
        endcase
        dec.known = (dec.fmt != FMT_NONE);
    end

    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    logic   main_v_q, main_v_d;
    logic   skid_v_q, skid_v_d;
    logic   rdy_q, rdy_d;
    logic   acc, pop;

    assign acc = bus.i_valid && rdy_q;
    assign pop = main_v_q && bus.i_ready;

    always_comb begin
        main_d   = main_q;
        main_v_d = main_v_q;
        skid_d   = skid_q;
        skid_v_d = skid_v_q;
        if (bus.i_flush) begin
            main_v_d = 1'b0;
            skid_v_d = 1'b0;
        end else if (pop && skid_v_q) begin
            main_d   = skid_q;
            skid_v_d = acc;
            if (acc) skid_d = dec;
        end else if (acc && (!main_v_q || pop)) begin
            main_d   = dec;
            main_v_d = 1'b1;
        end else if (acc) begin
            skid_d   = dec;
            skid_v_d = 1'b1;
        end else if (pop) begin
            main_v_d = 1'b0;
        end
        // registered so o_ready never depends on i_ready
        rdy_d = !skid_v_d;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            main_q   <= '0;
            skid_q   <= '0;
            main_v_q <= 1'b0;
            skid_v_q <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            main_q   <= main_d;
            skid_q   <= skid_d;
            main_v_q <= main_v_d;
            skid_v_q <= skid_v_d;
            rdy_q    <= rdy_d;
        end
    end

    assign bus.o_ready = rdy_q;
    assign bus.o_valid = main_v_q;
    assign bus.o_imm   = main_q.imm;
    assign bus.o_fmt   = main_q.fmt;
    assign bus.o_known = main_q.known;
endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 The module SHALL have parameter XLEN, default 32, which sets the immediate output width and is legal only as 32 or 64.
REQ-002 The module SHALL have parameter EN_CSR, default 1; when 1, SYSTEM-opcode CSR immediate decode is enabled.
REQ-003 The module SHALL have parameter EN_SHAMT, default 1; when 1, shift-immediate instructions output a zero-extended shamt instead of the full I immediate.
REQ-004 The module SHALL use one clock and an asynchronous active-low reset, ports listed first:
  i_clk    input   1       clock; all state updates on its rising edge
  i_rst_n  input   1       asynchronous active-low reset
  i_flush  input   1       synchronous flush of all buffered entries
  i_valid  input   1       upstream instruction valid
  o_ready  output  1       module can accept an instruction this cycle
  i_instr  input   32      instruction word
  o_valid  output  1       output entry valid
  i_ready  input   1       downstream accepts the output entry
  o_imm    output  XLEN    decoded immediate
  o_fmt    output  3       format: 0 none, 1 I, 2 S, 3 B, 4 U, 5 J, 6 CSR
  o_known  output  1       opcode recognised, meaning o_fmt != 0

Function
REQ-005 Decode SHALL be keyed on i_instr[6:0]:
  - I-format: 0010011, 0000011, 1100111
  - S-format: 0100011
  - B-format: 1100011
  - U-format: 0110111, 0010111
  - J-format: 1101111
  - CSR-format: 1110011, only when EN_CSR=1 and instr[14]=1
REQ-006 I immediate SHALL be instr[31:20], sign-extended to XLEN.
REQ-007 S immediate SHALL be {instr[31:25], instr[11:7]}, sign-extended to XLEN.
REQ-008 B immediate SHALL be {instr[31], instr[7], instr[30:25], instr[11:8], 0}, sign-extended from bit 12 to XLEN.
REQ-009 J immediate SHALL be {instr[31], instr[19:12], instr[20], instr[30:21], 0}, sign-extended from bit 20 to XLEN.
REQ-010 U immediate SHALL be {instr[31:12], 12'b0}, sign-extended from bit 31 to XLEN; for XLEN=32 this is a plain concatenation.
REQ-011 CSR immediate SHALL be instr[19:15], zero-extended to XLEN.
REQ-012 Shift-immediate handling SHALL apply when EN_SHAMT=1, opcode is 0010011 and funct3 is 001 or 101:
  - o_imm = instr[24:20] zero-extended for XLEN=32
  - o_imm = instr[25:20] zero-extended for XLEN=64
  - o_fmt = 1
REQ-013 For an unrecognised opcode, the entry SHALL carry o_imm=0, o_fmt=0, o_known=0; the entry is still passed through, not dropped.
REQ-014 Storage SHALL be a 2-entry elastic buffer, each entry holding the decoded {imm, fmt, known}:
  - main register drives the outputs
  - skid register holds one overflow entry
  - decode is combinational on i_instr before capture
REQ-015 Ready and valid SHALL be derived from state:
  - o_ready = skid empty, driven from a register with no combinational path from i_ready
  - o_valid = main register full
REQ-016 Accept SHALL occur when i_valid && o_ready; pop SHALL occur when o_valid && i_ready.
REQ-017 On accept with main empty, or with a pop and skid empty, the decoded input SHALL load main.
REQ-018 On accept with main full and no pop, the decoded input SHALL load skid.
REQ-019 On pop with skid full, skid SHALL move to main; a simultaneous accept loads skid in the same cycle.
REQ-020 On pop with skid empty and no accept, main SHALL be emptied.
REQ-021 Latency SHALL be exactly 1 cycle from accept to o_valid when the buffer is empty.
REQ-022 Sustained throughput SHALL be 1 instruction per cycle while i_ready=1.
REQ-023 Entries SHALL leave in acceptance order, with no loss and no duplication under any i_ready pattern.
REQ-024 i_flush=1 SHALL empty both entries on the next edge:
  - o_valid=0 and o_ready=1 afterwards
  - an accept in the flush cycle is discarded (flush wins)
  - the pop handshake that cycle is still honoured
REQ-025 Outputs SHALL be stable while o_valid=1 and i_ready=0.

Reset
REQ-026 While i_rst_n=0, the module SHALL drive o_valid=0, o_ready=0, o_imm=0, o_fmt=0, o_known=0, with both entries empty.
REQ-027 o_ready SHALL rise on the first clock edge after i_rst_n deasserts.
REQ-028 Reset asserted mid-operation SHALL discard all buffered entries immediately, without waiting for a clock edge.

Verification
REQ-029 The bench SHALL cover these directed scenarios (XLEN=32 unless stated):
  - 0xFFF00093 (addi -1) -> one cycle later o_imm=0xFFFFFFFF, o_fmt=1
  - 0xFE000FE3 (beq -2) -> o_imm=0xFFFFFFFE, o_fmt=3
  - 0x123450B7 (lui) -> o_imm=0x12345000, o_fmt=4
  - XLEN=64, 0x800000B7 -> o_imm=0xFFFFFFFF80000000
  - 0x4030D093 (srai 3) -> o_imm=3; 0x340FD073 (csrrwi 31) -> o_imm=0x1F, o_fmt=6; 0x0000007F -> o_known=0, o_imm=0
  - Backpressure: i_ready=0, offer A, B, C back-to-back -> A in main, B in skid, o_ready=0, C held upstream; then i_ready=1 -> A, B, C delivered in order, one per cycle
  - Flush with main and skid full plus a simultaneous accept -> next cycle o_valid=0, o_ready=1, no entry emitted
  - Reset mid-stream -> outputs 0 immediately; after reset release, a fresh addi decodes correctly
